// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: read-path controller for a 2-master / 4-slave AXI interconnect.
//   Arbitrates AR requests from m0 (cpu) and m1 (dmac) with round-robin priority.
//   Decodes the slave from the top two address bits and holds grant and select
//   until the burst ends. Checks the beat count against the latched ARLEN.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   mX_arvalid_i/araddr_i/arlen_i     AR request from master X
//   mX_arready_o                      ARREADY returned to master X
//   s_arready_i, s_rvalid_i, s_rlast_i  handshake signals of the selected slave
//   m_rready_i                        RREADY of the granted master
//   arvalid_o                         ARVALID toward the selected slave
//   mX_rgrnt_o, s_rsel_o              one-hot grant and slave index for the muxes
//   busy_o, len_err_o, err_cnt_o      status: in transaction, length error pulse, error count
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_BITS   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_arvalid_i,
    input  logic [ADDR_WIDTH-1:0] m0_araddr_i,
    input  logic [LEN_BITS-1:0]   m0_arlen_i,
    input  logic                  m1_arvalid_i,
    input  logic [ADDR_WIDTH-1:0] m1_araddr_i,
    input  logic [LEN_BITS-1:0]   m1_arlen_i,
    output logic                  m0_arready_o,
    output logic                  m1_arready_o,
    input  logic                  s_arready_i,
    input  logic                  s_rvalid_i,
    input  logic                  s_rlast_i,
    input  logic                  m_rready_i,
    output logic                  arvalid_o,
    output logic                  m0_rgrnt_o,
    output logic                  m1_rgrnt_o,
    output logic [1:0]            s_rsel_o,
    output logic                  busy_o,
    output logic                  len_err_o,
    output logic [7:0]            err_cnt_o
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state_q, state_d;
    logic [1:0] grant_q, grant_d, s_rsel_q, s_rsel_d;
    logic [LEN_BITS-1:0] len_q, len_d, beat_cnt_q, beat_cnt_d;
    logic rr_ptr_q, rr_ptr_d, len_err_q, len_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic pick_m1, beat, len_hit;
    logic unused_addr;
    assign unused_addr = ^{m0_araddr_i[ADDR_WIDTH-3:0], m1_araddr_i[ADDR_WIDTH-3:0]};
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        s_rsel_d   = s_rsel_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        len_err_d  = 1'b0;
        // m1 wins when it is the only requester, or on contention when it holds priority
        pick_m1    = m1_arvalid_i & (~m0_arvalid_i | rr_ptr_q);
        beat       = s_rvalid_i & m_rready_i;
        len_hit    = beat_cnt_q == len_q;
        if (state_q == IDLE && (m0_arvalid_i | m1_arvalid_i)) begin
            state_d  = ADDR;
            grant_d  = pick_m1 ? 2'b10 : 2'b01;
            s_rsel_d = pick_m1 ? m1_araddr_i[ADDR_WIDTH-1 -: 2] : m0_araddr_i[ADDR_WIDTH-1 -: 2];
            len_d    = pick_m1 ? m1_arlen_i : m0_arlen_i;
        end
        if (state_q == ADDR && s_arready_i) begin
            state_d    = DATA;
            beat_cnt_d = '0;
        end
        if (state_q == DATA && beat) begin
            if (s_rlast_i | len_hit) begin
                // priority passes to the master that was not just served
                state_d   = IDLE;
                grant_d   = 2'b00;
                rr_ptr_d  = grant_q[0];
                len_err_d = s_rlast_i ^ len_hit;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
        err_cnt_d = err_cnt_q + {7'd0, len_err_d & (err_cnt_q != 8'hff)};
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            s_rsel_q   <= 2'b00;
            len_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
            len_err_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            s_rsel_q   <= s_rsel_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            len_err_q  <= len_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
    assign arvalid_o    = state_q == ADDR;
    assign m0_arready_o = arvalid_o & grant_q[0] & s_arready_i;
    assign m1_arready_o = arvalid_o & grant_q[1] & s_arready_i;
    assign m0_rgrnt_o   = grant_q[0];
    assign m1_rgrnt_o   = grant_q[1];
    assign s_rsel_o     = s_rsel_q;
    assign busy_o       = state_q != IDLE;
    assign len_err_o    = len_err_q;
    assign err_cnt_o    = err_cnt_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized transactions checked against a transaction-level model.
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m_rready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [7:0] m0_arlen, m1_arlen;
    logic m0_arready, m1_arready, arvalid, m0_rgrnt, m1_rgrnt, busy, len_err;
    logic [1:0] s_rsel;
    logic [7:0] err_cnt;
    int n_chk = 0;
    int n_fail = 0;
    bit rr = 1'b0;
    int exp_err_cnt = 0;

    axi_rd_arbiter #(.ADDR_WIDTH(32), .LEN_BITS(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_arvalid_i(m0_arvalid), .m0_araddr_i(m0_araddr), .m0_arlen_i(m0_arlen),
        .m1_arvalid_i(m1_arvalid), .m1_araddr_i(m1_araddr), .m1_arlen_i(m1_arlen),
        .m0_arready_o(m0_arready), .m1_arready_o(m1_arready),
        .s_arready_i(s_arready), .s_rvalid_i(s_rvalid), .s_rlast_i(s_rlast), .m_rready_i(m_rready),
        .arvalid_o(arvalid), .m0_rgrnt_o(m0_rgrnt), .m1_rgrnt_o(m1_rgrnt), .s_rsel_o(s_rsel),
        .busy_o(busy), .len_err_o(len_err), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle;
        chk("idle_busy", busy, 0);
        chk("idle_grant", {m1_rgrnt, m0_rgrnt}, 0);
        chk("idle_arvalid", arvalid, 0);
        chk("idle_arready", {m1_arready, m0_arready}, 0);
    endtask

    // One complete transaction started from an IDLE cycle; returns in the first IDLE cycle after it.
    // last_at: beat number carrying RLAST (0 = never); mode: 0 full rate, 1 rready 1,0,0 pattern, 2 random.
    task automatic run_txn(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [7:0] l0, input logic [7:0] l1,
                           input int ar_dly, input int last_at, input int mode);
        int w, nb, k;
        logic [1:0] sel;
        bit done, e;
        m0_arvalid = r0; m0_araddr = a0; m0_arlen = l0;
        m1_arvalid = r1; m1_araddr = a1; m1_arlen = l1;
        #1;
        check_idle();
        w   = (r0 && r1) ? int'(rr) : (r1 ? 1 : 0);
        sel = w ? a1[31:30] : a0[31:30];
        nb  = (w ? int'(l1) : int'(l0)) + 1;
        step();
        chk("req_grant", {m1_rgrnt, m0_rgrnt}, w ? 2 : 1);
        chk("req_sel", s_rsel, sel);
        chk("req_busy", busy, 1);
        chk("err_cnt", err_cnt, exp_err_cnt);
        m0_arvalid = 1'($urandom_range(0, 1)); m0_araddr = $urandom; m0_arlen = 8'($urandom);
        m1_arvalid = 1'($urandom_range(0, 1)); m1_araddr = $urandom; m1_arlen = 8'($urandom);
        for (int d = 0; d <= ar_dly; d++) begin
            s_arready = (d == ar_dly);
            #1;
            chk("addr_arvalid", arvalid, 1);
            chk("addr_m0_arready", m0_arready, (w == 0) && s_arready);
            chk("addr_m1_arready", m1_arready, (w == 1) && s_arready);
            chk("addr_grant", {m1_rgrnt, m0_rgrnt}, w ? 2 : 1);
            step();
        end
        s_arready = 1'b0;
        done = 1'b0;
        k = 1;
        for (int c = 0; c < nb * 16 + 40 && !done; c++) begin
            bit v, r, hs;
            v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            s_rvalid = v; m_rready = r; s_rlast = (k == last_at);
            hs = v && r;
            step();
            if (hs && (k == last_at || k == nb)) begin
                done = 1'b1;
                e = (k == last_at) != (k == nb);
                chk("end_len_err", len_err, e);
                chk("end_busy", busy, 0);
                chk("end_grant", {m1_rgrnt, m0_rgrnt}, 0);
                if (e && exp_err_cnt < 255) exp_err_cnt++;
                rr = (w == 0);
            end else begin
                chk("data_busy", busy, 1);
                chk("data_grant", {m1_rgrnt, m0_rgrnt}, w ? 2 : 1);
                chk("data_sel", s_rsel, sel);
                chk("data_len_err", len_err, 0);
                if (hs) k++;
            end
        end
        chk("burst_done", done, 1);
        s_rvalid = 0; m_rready = 0; s_rlast = 0; m0_arvalid = 0; m1_arvalid = 0;
    endtask

    initial begin
        rst = 1'b1;
        m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0;
        s_arready = 0; s_rvalid = 0; s_rlast = 0; m_rready = 0;
        repeat (3) step();
        check_idle();
        chk("rst_len_err", len_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_sel", s_rsel, 0);
        rst = 1'b0;
        step();
        // contention with arlen=0: m0, m1, m0, m1
        for (int i = 0; i < 4; i++) run_txn(1, 1, $urandom, $urandom, 0, 0, 0, 1, 0);
        // single read to slave 1 with ARREADY after two cycles
        run_txn(1, 0, 32'h4000_0010, 0, 3, 0, 2, 4, 0);
        // early RLAST on beat 3 of 8
        run_txn(1, 0, 32'hC000_0000, 0, 7, 0, 0, 3, 0);
        step();
        chk("early_err_cnt", err_cnt, exp_err_cnt);
        // missing RLAST on a 2-beat burst
        run_txn(0, 1, 0, 32'h8000_0100, 0, 1, 1, 0, 0);
        // backpressure on a 4-beat burst
        run_txn(1, 0, 32'h0000_0040, 0, 3, 0, 0, 4, 1);
        // maximum burst length
        run_txn(0, 1, 0, 32'h4000_0000, 0, 255, 0, 256, 0);
        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit q0, q1;
            logic [7:0] la, lb;
            int sel_last, lw;
            q0 = 1'($urandom_range(0, 1));
            q1 = q0 ? 1'($urandom_range(0, 1)) : 1'b1;
            la = 8'($urandom_range(0, 7));
            lb = 8'($urandom_range(0, 7));
            lw = ((q0 && q1) ? (rr ? lb : la) : (q1 ? lb : la)) + 1;
            sel_last = $urandom_range(0, 2);
            run_txn(q0, q1, $urandom, $urandom, la, lb, $urandom_range(0, 3),
                    sel_last == 0 ? lw : sel_last == 1 ? $urandom_range(1, lw) : 0,
                    $urandom_range(0, 2));
        end
        // drive the error counter into saturation
        for (int i = 0; i < 260; i++) run_txn(1, 1, $urandom, $urandom, 1, 1, 0, 1, 0);
        step();
        chk("sat_err_cnt", err_cnt, exp_err_cnt);
        // reset in the middle of a 4-beat burst, after beat 1
        m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arlen = 3;
        step();
        m0_arvalid = 0; s_arready = 1;
        step();
        s_arready = 0; s_rvalid = 1; m_rready = 1;
        step();
        s_rvalid = 0; m_rready = 0;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_grant", m0_rgrnt, 1);
        #2 rst = 1'b1;
        #1;
        check_idle();
        chk("mid_rst_len_err", len_err, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        exp_err_cnt = 0;
        rr = 1'b0;
        step();
        rst = 1'b0;
        run_txn(1, 1, 32'h4000_0000, 32'h8000_0000, 2, 0, 1, 3, 0);
        run_txn(0, 1, 0, 32'hC000_0020, 0, 3, 0, 4, 0);
        step();
        check_idle();
        chk("final_err_cnt", err_cnt, exp_err_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
